ram_arbiter_ctrl: RTL and testbench



---
 rtl/ram_arbiter_ctrl.sv | 124 ++++++++++++
 tb/tb_ram_arbiter_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_ctrl.sv
// Arbitrates CPU instruction and data requests onto a single-port synchronous RAM
// with fixed read latency, answering the core with wait/load handshakes.
module ram_arbiter_ctrl #(
    parameter int RAM_LAT = 1,
    parameter int ADDR_W  = 14
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iren,
    input  logic [31:0]       iaddr,
    input  logic              dren,
    input  logic [3:0]        dwen,
    input  logic [31:0]       daddr,
    input  logic [31:0]       dstore,
    output logic              iwait,
    output logic              dwait,
    output logic [31:0]       iload,
    output logic [31:0]       dload,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_ren,
    output logic [3:0]        ram_wen,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } state_t;

    localparam logic [2:0] LAT = 3'(RAM_LAT);

    state_t            state_reg, state_next;
    logic [2:0]        cnt_reg, cnt_next;
    logic              last_d_reg, last_d_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [3:0]        wen_reg, wen_next;
    logic [31:0]       wdata_reg, wdata_next;

    logic dreq, held, idone, ddone, acc, first;
    logic unused_addr_bits;

    assign dreq = dren | (|dwen);
    // Only the word-address slice of each byte address reaches the RAM.
    assign unused_addr_bits = ^{iaddr, daddr};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg  <= IDLE;
            cnt_reg    <= 3'd0;
            last_d_reg <= 1'b0;
            addr_reg   <= '0;
            wen_reg    <= 4'd0;
            wdata_reg  <= 32'd0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            last_d_reg <= last_d_next;
            addr_reg   <= addr_next;
            wen_reg    <= wen_next;
            wdata_reg  <= wdata_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        last_d_next = last_d_reg;
        addr_next   = addr_reg;
        wen_next    = wen_reg;
        wdata_next  = wdata_reg;
        held        = 1'b0;
        idone       = 1'b0;
        ddone       = 1'b0;
        case (state_reg)
            IDLE: begin
                // Data wins unless it was served last and an instruction fetch is waiting.
                if (dreq && !(iren && last_d_reg)) begin
                    state_next = DACC;
                    cnt_next   = LAT;
                    addr_next  = daddr[ADDR_W+1:2];
                    wen_next   = dwen;
                    wdata_next = dstore;
                end else if (iren) begin
                    state_next = IACC;
                    cnt_next   = LAT;
                    addr_next  = iaddr[ADDR_W+1:2];
                    wen_next   = 4'd0;
                    wdata_next = 32'd0;
                end
            end
            DACC, IACC: begin
                held = (state_reg == IACC) ? iren : dreq;
                if (!held) begin
                    state_next = IDLE;
                end else if (cnt_reg == 3'd0) begin
                    state_next  = IDLE;
                    last_d_next = (state_reg == DACC);
                    idone       = (state_reg == IACC);
                    ddone       = (state_reg == DACC);
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        acc   = (state_reg != IDLE);
        first = (cnt_reg == LAT);
        // Writes strobe the RAM once, in the first cycle of the access.
        ram_addr  = acc ? addr_reg : '0;
        ram_ren   = acc && (wen_reg == 4'd0);
        ram_wen   = (acc && first) ? wen_reg : 4'd0;
        ram_wdata = (acc && first && (wen_reg != 4'd0)) ? wdata_reg : 32'd0;
        iload     = idone ? ram_rdata : 32'd0;
        dload     = (ddone && (wen_reg == 4'd0)) ? ram_rdata : 32'd0;
        iwait     = iren & ~idone;
        dwait     = dreq & ~ddone;
    end

endmodule

// File: tb/tb_ram_arbiter_ctrl.sv
// Drives two arbiters (RAM_LAT 1 and 3) with directed and random CPU traffic and
// compares every output each cycle against a transaction-level reference model.
module tb_ram_arbiter_ctrl;

    localparam int NI = 2;
    localparam int AW = 14;
    localparam int MW = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst   = 1'b0;
    logic        iren   = 1'b0;
    logic        dren   = 1'b0;
    logic [3:0]  dwen   = 4'd0;
    logic [31:0] iaddr  = 32'd0;
    logic [31:0] daddr  = 32'd0;
    logic [31:0] dstore = 32'd0;

    logic          iwait_a     [NI];
    logic          dwait_a     [NI];
    logic [31:0]   iload_a     [NI];
    logic [31:0]   dload_a     [NI];
    logic [AW-1:0] ram_addr_a  [NI];
    logic          ram_ren_a   [NI];
    logic [3:0]    ram_wen_a   [NI];
    logic [31:0]   ram_wdata_a [NI];
    logic [31:0]   ram_rdata_a [NI];

    function automatic logic [31:0] mem_init(int i);
        if (i == 'h10) return 32'hDEADBEEF;
        if (i == 'h20) return 32'hAABBCCDD;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_inst
            localparam int LAT = (gi == 0) ? 1 : 3;
            logic [31:0] mem [0:MW-1];
            logic [31:0] pipe [LAT];

            ram_arbiter_ctrl #(.RAM_LAT(LAT), .ADDR_W(AW)) u_dut (
                .CLK       (clk),
                .nRST      (nrst),
                .iren      (iren),
                .iaddr     (iaddr),
                .dren      (dren),
                .dwen      (dwen),
                .daddr     (daddr),
                .dstore    (dstore),
                .iwait     (iwait_a[gi]),
                .dwait     (dwait_a[gi]),
                .iload     (iload_a[gi]),
                .dload     (dload_a[gi]),
                .ram_addr  (ram_addr_a[gi]),
                .ram_ren   (ram_ren_a[gi]),
                .ram_wen   (ram_wen_a[gi]),
                .ram_wdata (ram_wdata_a[gi]),
                .ram_rdata (ram_rdata_a[gi])
            );

            initial begin
                for (int i = 0; i < MW; i++) mem[i] = mem_init(i);
            end

            // Synchronous RAM: data for an address read in cycle c appears in cycle c+LAT.
            always @(posedge clk) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wen_a[gi][b]) mem[ram_addr_a[gi]][8*b +: 8] <= ram_wdata_a[gi][8*b +: 8];
                pipe[0] <= ram_ren_a[gi] ? mem[ram_addr_a[gi]] : 32'hBAD0BAD0;
                for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
            end
            assign ram_rdata_a[gi] = pipe[LAT-1];
        end
    endgenerate

    // Reference model: who owns the RAM, how long the access has run, what was latched.
    int          own   [NI];   // 0 none, 1 instruction, 2 data
    int          el    [NI];
    logic        lastd [NI];
    logic [AW-1:0] la  [NI];
    logic [3:0]  lw    [NI];
    logic [31:0] ld    [NI];
    logic [31:0] mmem  [NI][0:MW-1];
    int          irun  [NI];
    int          imax  [NI];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic        s_nrst, s_iren, s_dren;
    logic [3:0]  s_dwen;
    logic [31:0] s_iaddr, s_daddr, s_dstore;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        nrst   = s_nrst;
        iren   = s_iren;
        dren   = s_dren;
        dwen   = s_dwen;
        iaddr  = s_iaddr;
        daddr  = s_daddr;
        dstore = s_dstore;
        #1;
        for (int k = 0; k < NI; k++) begin
            int          lat;
            logic        dreq, held, done, acc;
            logic [3:0]  e_wen;
            logic [31:0] e_wdata, e_iload, e_dload;
            lat  = (k == 0) ? 1 : 3;
            dreq = s_dren | (|s_dwen);
            if (!s_nrst) begin
                own[k] = 0; el[k] = 0; lastd[k] = 1'b0;
            end
            acc     = (own[k] != 0);
            held    = (own[k] == 1) ? s_iren : ((own[k] == 2) ? dreq : 1'b0);
            done    = acc && held && (el[k] == lat);
            e_wen   = (acc && el[k] == 0) ? lw[k] : 4'd0;
            e_wdata = (e_wen != 4'd0) ? ld[k] : 32'd0;
            e_iload = (done && own[k] == 1) ? mmem[k][la[k]] : 32'd0;
            e_dload = (done && own[k] == 2 && lw[k] == 4'd0) ? mmem[k][la[k]] : 32'd0;

            check($sformatf("i%0d_iwait", k), 32'(iwait_a[k]), 32'(s_iren & ~(done && own[k] == 1)));
            check($sformatf("i%0d_dwait", k), 32'(dwait_a[k]), 32'(dreq & ~(done && own[k] == 2)));
            check($sformatf("i%0d_iload", k), iload_a[k], e_iload);
            check($sformatf("i%0d_dload", k), dload_a[k], e_dload);
            check($sformatf("i%0d_ram_ren", k), 32'(ram_ren_a[k]), 32'(acc && lw[k] == 4'd0));
            check($sformatf("i%0d_ram_wen", k), 32'(ram_wen_a[k]), 32'(e_wen));
            check($sformatf("i%0d_ram_wdata", k), ram_wdata_a[k], e_wdata);
            if (acc || !s_nrst)
                check($sformatf("i%0d_ram_addr", k), 32'(ram_addr_a[k]), acc ? 32'(la[k]) : 32'd0);

            if (iwait_a[k]) irun[k]++; else irun[k] = 0;
            if (irun[k] > imax[k]) imax[k] = irun[k];
            if (done)
                $display("inst%0d cyc %0d %s addr %h data %h", k, cyc,
                         (own[k] == 1) ? "ifetch" : ((lw[k] != 4'd0) ? "dwrite" : "dread"),
                         la[k], (own[k] == 1) ? e_iload : ((lw[k] != 4'd0) ? ld[k] : e_dload));

            if (s_nrst) begin
                if (acc && el[k] == 0 && lw[k] != 4'd0)
                    for (int b = 0; b < 4; b++)
                        if (lw[k][b]) mmem[k][la[k]][8*b +: 8] = ld[k][8*b +: 8];
                if (!acc) begin
                    if (dreq && !(s_iren && lastd[k])) begin
                        own[k] = 2; el[k] = 0;
                        la[k] = s_daddr[AW+1:2]; lw[k] = s_dwen; ld[k] = s_dstore;
                    end else if (s_iren) begin
                        own[k] = 1; el[k] = 0;
                        la[k] = s_iaddr[AW+1:2]; lw[k] = 4'd0; ld[k] = 32'd0;
                    end
                end else if (!held) begin
                    own[k] = 0;
                end else if (done) begin
                    lastd[k] = (own[k] == 2);
                    own[k]   = 0;
                end else begin
                    el[k]++;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle2();
        s_iren = 1'b0; s_dren = 1'b0; s_dwen = 4'd0;
        step();
        step();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        logic [4:0]  w;
        r = $urandom;
        w = 5'($urandom_range(0, 31));
        return {r[31:16], 9'd0, w, r[1:0]};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            own[k] = 0; el[k] = 0; lastd[k] = 1'b0; la[k] = '0; lw[k] = 4'd0; ld[k] = 32'd0;
            irun[k] = 0; imax[k] = 0;
            for (int i = 0; i < MW; i++) mmem[k][i] = mem_init(i);
        end
        s_nrst = 1'b0; s_iren = 1'b1; s_dren = 1'b1; s_dwen = 4'd0;
        s_iaddr = 32'h40; s_daddr = 32'h80; s_dstore = 32'd0;

        // Reset: waits follow requests, RAM idle.
        step();
        step();
        check("rst_iwait", 32'(iwait_a[0]), 32'd1);
        check("rst_dwait", 32'(dwait_a[1]), 32'd1);
        check("rst_ren", 32'(ram_ren_a[0]), 32'd0);
        s_nrst = 1'b1;
        idle2();

        // Instruction fetch of preloaded word 0x10.
        s_iren = 1'b1; s_iaddr = 32'h40;
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 1) check("t1_addr", 32'(ram_addr_a[0]), 32'h10);
            if (c == 2) begin
                check("t1_iwait", 32'(iwait_a[0]), 32'd0);
                check("t1_iload", iload_a[0], 32'hDEADBEEF);
            end
            if (c == 4) check("t1_iload_lat3", iload_a[1], 32'hDEADBEEF);
        end
        idle2();

        // Half-word write then read-back.
        s_dwen = 4'b0011; s_daddr = 32'h80; s_dstore = 32'h12345678;
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 1) begin
                check("t2_wen", 32'(ram_wen_a[0]), 32'h3);
                check("t2_wdata", ram_wdata_a[0], 32'h12345678);
            end
            if (c == 2) begin
                check("t2_wen_once", 32'(ram_wen_a[0]), 32'h0);
                check("t2_dwait", 32'(dwait_a[0]), 32'd0);
            end
            if (c == 4) check("t2_dwait_lat3", 32'(dwait_a[1]), 32'd0);
        end
        idle2();
        s_dren = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 2) check("t2_dload", dload_a[0], 32'hAABB5678);
            if (c == 4) check("t2_dload_lat3", dload_a[1], 32'hAABB5678);
        end
        idle2();

        // Both streams held: grants alternate, instruction side never starves.
        s_iren = 1'b1; s_dren = 1'b1; s_iaddr = 32'h44; s_daddr = 32'h84;
        for (int k = 0; k < NI; k++) begin irun[k] = 0; imax[k] = 0; end
        for (int c = 0; c < 24; c++) step();
        check("t3_starve_l1", 32'(imax[0] <= 6), 32'd1);
        check("t3_starve_l3", 32'(imax[1] <= 10), 32'd1);
        idle2();

        // Data withdrawn mid-access, then an instruction fetch.
        s_dren = 1'b1; s_daddr = 32'h80;
        step();
        s_dren = 1'b0; s_iren = 1'b1; s_iaddr = 32'h40;
        for (int c = 1; c < 7; c++) begin
            step();
            if (c == 2) check("t5_idle", 32'(ram_ren_a[0]), 32'd0);
            if (c == 4) check("t5_iload", iload_a[0], 32'hDEADBEEF);
            if (c == 6) check("t5_iload_lat3", iload_a[1], 32'hDEADBEEF);
        end
        idle2();

        // Reset pulsed during an instruction access.
        s_iren = 1'b1;
        step();
        s_nrst = 1'b0;
        step();
        check("t6_ren", 32'(ram_ren_a[0]), 32'd0);
        check("t6_iload", iload_a[0], 32'd0);
        check("t6_iwait", 32'(iwait_a[0]), 32'd1);
        s_nrst = 1'b1;
        for (int c = 2; c < 5; c++) begin
            step();
            if (c == 4) check("t6_reserve", iload_a[0], 32'hDEADBEEF);
        end
        idle2();

        // Random traffic with withdrawals, address churn and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] r;
            r = $urandom;
            if (r[2:0] == 3'd0) s_iren = ~s_iren;
            if (r[5:3] == 3'd0) begin
                case ($urandom_range(0, 3))
                    0: begin s_dren = 1'b0; s_dwen = 4'd0; end
                    1: begin s_dren = 1'b1; s_dwen = 4'd0; end
                    2: begin s_dren = 1'b0; s_dwen = 4'($urandom_range(1, 15)); end
                    default: begin s_dren = 1'b1; s_dwen = 4'($urandom_range(1, 15)); end
                endcase
            end
            if (r[7:6] == 2'd0) s_iaddr = rand_addr();
            if (r[9:8] == 2'd0) s_daddr = rand_addr();
            if (r[11:10] == 2'd0) s_dstore = $urandom;
            s_nrst = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
